// File: rtl/buzzer_tone_seq_if.sv
// Control/status bundle for the buzzer tone sequencer: start/abort request,
// run-time tone configuration, and busy/done/pwm status back to the requester.
interface buzzer_tone_seq_if #(
    parameter int DIV_W  = 20,
    parameter int TIME_W = 16,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              abort;
    logic [DIV_W-1:0]  half_period;
    logic [TIME_W-1:0] on_time;
    logic [TIME_W-1:0] off_time;
    logic [CNT_W-1:0]  repeat_count;
    logic              busy;
    logic              done;
    logic              pwm_out;

    modport master (
        output start, abort, half_period, on_time, off_time, repeat_count,
        input  busy, done, pwm_out
    );

    modport slave (
        input  start, abort, half_period, on_time, off_time, repeat_count,
        output busy, done, pwm_out
    );
endinterface

// File: rtl/buzzer_tone_seq.sv
// Burst buzzer: square wave of programmable half-period, gated into N beeps of
// on_time ticks separated by off_time ticks of silence.
module buzzer_tone_seq #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int DIV_W      = 20,
    parameter int TIME_W     = 16,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    buzzer_tone_seq_if.slave   bus
);

    localparam int TICK_DIV = CLOCK_FREQ / TICK_HZ;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q;
    logic [TIME_W-1:0] dur_q;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  beep_q;
    logic [DIV_W-1:0]  hp_q;
    logic [TIME_W-1:0] on_q, off_q;
    logic [CNT_W-1:0]  rep_q;
    logic              pwm_q, done_q;

    logic              tick, phase_end;
    logic              accept, enter_tone, enter_gap, done_d;
    logic [DIV_W-1:0]  tone_hp;
    logic [TIME_W-1:0] tone_on;

    assign tick      = (pre_q == PRE_MAX);
    assign phase_end = tick && (dur_q == TIME_W'(1));

    // A tone entered straight from IDLE must use the config being latched now.
    assign tone_hp = accept ? bus.half_period : hp_q;
    assign tone_on = accept ? bus.on_time     : on_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        accept     = 1'b0;
        enter_tone = 1'b0;
        enter_gap  = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    accept = 1'b1;
                    if (bus.half_period == '0 || bus.on_time == '0 ||
                        bus.repeat_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = TONE;
                        enter_tone = 1'b1;
                    end
                end
            end
            TONE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (phase_end) begin
                    if (beep_q + 1'b1 == rep_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (off_q == '0) begin
                        enter_tone = 1'b1;
                    end else begin
                        state_d   = GAP;
                        enter_gap = 1'b1;
                    end
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (phase_end) begin
                    state_d    = TONE;
                    enter_tone = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            dur_q  <= '0;
            div_q  <= '0;
            beep_q <= '0;
            hp_q   <= '0;
            on_q   <= '0;
            off_q  <= '0;
            rep_q  <= '0;
            pwm_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;

            if (accept) begin
                hp_q   <= bus.half_period;
                on_q   <= bus.on_time;
                off_q  <= bus.off_time;
                rep_q  <= bus.repeat_count;
                beep_q <= '0;
            end else if (state_q == TONE && phase_end && !bus.abort) begin
                beep_q <= beep_q + 1'b1;
            end

            // Every state entry restarts the prescaler and forces silence.
            if (enter_tone) begin
                pre_q <= '0;
                dur_q <= tone_on;
                div_q <= tone_hp - 1'b1;
                pwm_q <= 1'b0;
            end else if (enter_gap) begin
                pre_q <= '0;
                dur_q <= off_q;
                pwm_q <= 1'b0;
            end else if (state_d == IDLE) begin
                pre_q <= '0;
                dur_q <= '0;
                div_q <= '0;
                pwm_q <= 1'b0;
            end else begin
                pre_q <= tick ? '0 : pre_q + 1'b1;
                if (tick) dur_q <= dur_q - 1'b1;
                if (state_q == TONE) begin
                    if (div_q == '0) begin
                        pwm_q <= ~pwm_q;
                        div_q <= hp_q - 1'b1;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
            end
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.pwm_out = pwm_q;

endmodule

// File: tb/tb_buzzer_tone_seq.sv
// Bench for buzzer_tone_seq: a time-based burst model checked every cycle,
// plus directed scenarios with hand-computed waveform points.
module tb_buzzer_tone_seq;

    localparam int CLOCK_FREQ = 100;
    localparam int TICK_HZ    = 10;
    localparam int TD         = CLOCK_FREQ / TICK_HZ;
    localparam int DIV_W      = 20;
    localparam int TIME_W     = 16;
    localparam int CNT_W      = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    int   e0 = 0;

    buzzer_tone_seq_if #(.DIV_W(DIV_W), .TIME_W(TIME_W), .CNT_W(CNT_W)) bus ();

    buzzer_tone_seq #(
        .CLOCK_FREQ(CLOCK_FREQ), .TICK_HZ(TICK_HZ),
        .DIV_W(DIV_W), .TIME_W(TIME_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: a running sequence is just "t cycles since the start edge".
    // Beep k spans [k*P, k*P+L) with L = on*TD, P = L + off*TD; inside a beep
    // the output is high when floor(position/half_period) is odd.
    logic m_active = 1'b0;
    logic m_done = 1'b0;
    int   m_t = 0, m_total = 0, m_hp = 0, m_on = 0, m_off = 0;

    function automatic int seq_len(input int on, input int off, input int rep);
        return rep * on * TD + (rep - 1) * off * TD;
    endfunction

    function automatic logic model_pwm(input int t, input int hp, input int on, input int off);
        int l, p;
        l = on * TD;
        p = t % (l + off * TD);
        return (p < l) && (((p / hp) % 2) == 1);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_t      <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (bus.abort) begin
                    m_active <= 1'b0;
                end else if (m_t + 1 == m_total) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_t <= m_t + 1;
                end
            end else if (bus.start && !bus.abort) begin
                m_hp    <= int'(bus.half_period);
                m_on    <= int'(bus.on_time);
                m_off   <= int'(bus.off_time);
                m_total <= seq_len(int'(bus.on_time), int'(bus.off_time), int'(bus.repeat_count));
                if (bus.half_period == 0 || bus.on_time == 0 || bus.repeat_count == 0) begin
                    m_done <= 1'b1;
                end else begin
                    m_active <= 1'b1;
                    m_t      <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(bus.busy), 32'(m_active));
        check("done", 32'(bus.done), 32'(m_done));
        check("pwm_out", 32'(bus.pwm_out),
              32'(m_active && model_pwm(m_t, m_hp, m_on, m_off)));
    end

    // Called at a negedge; returns at the negedge following the start edge E0.
    task automatic kick(input int hp, input int on, input int off, input int rep);
        bus.half_period  = DIV_W'(hp);
        bus.on_time      = TIME_W'(on);
        bus.off_time     = TIME_W'(off);
        bus.repeat_count = CNT_W'(rep);
        bus.start        = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic at_off(input int off);
        while (cyc < e0 + off) @(negedge clk);
    endtask

    task automatic pin(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.half_period = '0; bus.on_time = '0; bus.off_time = '0; bus.repeat_count = '0;
        repeat (3) @(negedge clk);
        pin("reset_busy", bus.busy, 1'b0);
        pin("reset_pwm", bus.pwm_out, 1'b0);
        pin("reset_done", bus.done, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Burst: hp=2, on=3, off=2, repeat=2; start re-pulsed mid-tone is ignored.
        kick(2, 3, 2, 2);
        pin("a_busy_e0", bus.busy, 1'b1);
        pin("a_pwm_e0", bus.pwm_out, 1'b0);
        at_off(2);  pin("a_pwm_2", bus.pwm_out, 1'b1);
        at_off(4);  pin("a_pwm_4", bus.pwm_out, 1'b0);
        at_off(9);
        bus.half_period = 20'd5; bus.on_time = 16'd1; bus.repeat_count = 8'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        at_off(27); pin("a_pwm_27", bus.pwm_out, 1'b1);
        at_off(30); pin("a_pwm_30", bus.pwm_out, 1'b0);
        at_off(50); pin("a_busy_50", bus.busy, 1'b1);
        at_off(52); pin("a_pwm_52", bus.pwm_out, 1'b1);
        at_off(79); pin("a_busy_79", bus.busy, 1'b1);
        at_off(80); pin("a_done_80", bus.done, 1'b1);
        pin("a_busy_80", bus.busy, 1'b0);

        // Start in the done cycle, off_time=0: beeps run back-to-back.
        kick(2, 3, 0, 2);
        pin("b_busy_e0", bus.busy, 1'b1);
        pin("b_done_e0", bus.done, 1'b0);
        at_off(29); pin("b_pwm_29", bus.pwm_out, 1'b0);
        at_off(30); pin("b_pwm_30", bus.pwm_out, 1'b0);
        at_off(32); pin("b_pwm_32", bus.pwm_out, 1'b1);
        at_off(60); pin("b_done_60", bus.done, 1'b1);
        at_off(61); pin("b_done_61", bus.done, 1'b0);

        // Degenerate configs finish immediately without going busy.
        kick(2, 3, 2, 0);
        pin("z_rep_done", bus.done, 1'b1);
        pin("z_rep_busy", bus.busy, 1'b0);
        at_off(1);  pin("z_rep_done1", bus.done, 1'b0);
        kick(0, 3, 2, 1);
        pin("z_hp_done", bus.done, 1'b1);
        kick(2, 0, 2, 1);
        pin("z_on_done", bus.done, 1'b1);
        at_off(2);

        // Abort during the first gap.
        kick(2, 3, 2, 2);
        at_off(44);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        pin("ab_busy_45", bus.busy, 1'b0);
        pin("ab_pwm_45", bus.pwm_out, 1'b0);
        at_off(90); pin("ab_done_90", bus.done, 1'b0);

        // start with abort is refused; a clean start afterwards works.
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        pin("sa_busy", bus.busy, 1'b0);
        kick(3, 1, 1, 3);
        at_off(3);  pin("c_pwm_3", bus.pwm_out, 1'b1);
        at_off(9);  pin("c_pwm_9", bus.pwm_out, 1'b1);
        at_off(10); pin("c_pwm_10", bus.pwm_out, 1'b0);
        at_off(23); pin("c_pwm_23", bus.pwm_out, 1'b1);
        at_off(50); pin("c_done_50", bus.done, 1'b1);

        // Asynchronous reset mid-tone clears outputs without a clock edge.
        kick(2, 3, 2, 2);
        at_off(18);
        pin("r_pwm_18", bus.pwm_out, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        pin("r_async_pwm", bus.pwm_out, 1'b0);
        pin("r_async_busy", bus.busy, 1'b0);
        pin("r_async_done", bus.done, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        kick(2, 1, 0, 1);
        at_off(9);  pin("r2_busy_9", bus.busy, 1'b1);
        at_off(10); pin("r2_done_10", bus.done, 1'b1);
        at_off(13);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/buzzer_tone_seq.md
Name: buzzer_tone_seq

Overview:
Programmable buzzer tone sequencer. It generates a square-wave tone with a run-time half-period, gated into a burst pattern: N beeps of on_time ticks, separated by off_time ticks of silence. It replaces the fixed-frequency buzzer driver in alarm/status paths and is started by a one-cycle start pulse from control logic, with busy/done status returned.

Parameters:
CLOCK_FREQ, 100_000_000, system clock frequency in Hz
TICK_HZ, 1000, time-base rate for on/off durations (default 1 ms ticks); TICK_DIV = CLOCK_FREQ/TICK_HZ, must be >= 1
DIV_W, 20, width of the half_period input (clock cycles)
TIME_W, 16, width of the on_time/off_time inputs (ticks)
CNT_W, 8, width of the repeat input (beep count)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; latches config and starts a sequence when busy=0
abort  in  1  synchronous stop; returns to idle immediately
half_period  in  DIV_W  tone half-period in clk cycles; sampled on accepted start
on_time  in  TIME_W  beep length in ticks; sampled on accepted start
off_time  in  TIME_W  gap length in ticks; sampled on accepted start
repeat  in  CNT_W  number of beeps; sampled on accepted start
busy  out  1  high while a sequence runs
done  out  1  one-cycle pulse when a sequence completes normally
pwm_out  out  1  buzzer drive

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE; pwm_out=0, busy=0, done=0; all counters 0.
- States: IDLE, TONE, GAP. busy=1 in TONE and GAP, and 0 in IDLE.
- IDLE: start=1 and abort=0 at an edge: latch all four config inputs. If half_period==0, on_time==0 or repeat==0, stay in IDLE with busy=0 and pulse done=1 for the next cycle. Otherwise go to TONE at that edge.
- Start while busy=1 is ignored. The config inputs may change freely after acceptance.
- Time base: the prescaler restarts on every state entry. A state lasting T ticks lasts exactly T*TICK_DIV clk cycles.
- TONE entry: pwm_out=0 and the divider loads half_period-1. Each clk the divider decrements. At 0, pwm_out toggles and the divider reloads. The first toggle comes half_period cycles after entry.
- TONE exit, after on_time ticks: the beep counter increments and pwm_out is forced to 0. The exit takes precedence over a coincident toggle.
  - If beeps done == repeat: go to IDLE, busy=0, done=1 for one cycle.
  - Else if off_time==0: re-enter TONE directly, with a fresh divider and pwm_out=0.
  - Else: go to GAP.
- GAP: pwm_out held 0. After off_time ticks, go to TONE. There is never a gap after the last beep.
- abort=1 at an edge in TONE/GAP: go to IDLE, pwm_out=0, busy=0, done stays 0. abort in IDLE has no effect. start and abort together: abort wins, start is not accepted.
- Reset mid-sequence: immediate return to reset values, no done.
- done is registered and high for exactly one cycle, in the cycle following the completing edge. A start in that cycle is accepted.
- Counters: divider DIV_W bits, duration TIME_W bits, beep count CNT_W bits. None wraps within a legal sequence. Maximum values (all ones) are legal.

Test Plan:
CLOCK_FREQ=100, TICK_HZ=10 (TICK_DIV=10), half_period=2, on_time=3, off_time=2, repeat=2, start at edge E0 -> busy=1 from E0 to E0+80. pwm_out toggles at E0+2, +4, …, +28 (7 high pulses), is forced 0 at E0+30, stays 0 through E0+50, then toggles again at E0+52…E0+78. done=1 for one cycle after E0+80.
Same config with off_time=0 -> second beep starts at E0+30, pwm_out=0 at E0+30 then first toggle at E0+32, done after E0+60.
repeat=0 (or half_period=0) with start -> busy stays 0, pwm_out stays 0, done pulses one cycle after the start edge.
abort at E0+45 during GAP of the first scenario -> busy=0 and pwm_out=0 after E0+45, no done, no further toggles. A new start is then accepted normally.
start re-pulsed at E0+10 with different config -> ignored; waveform identical to the first scenario. start in the done cycle -> new sequence begins at that edge.
reset_n low asynchronously at E0+17 mid-TONE -> pwm_out, busy, done go to 0 without a clock edge. After release, start behaves as from power-up.
